// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE operand accumulator slice.
package pe_pkg;

  localparam int PE_DATA_W = 8;
  localparam int PE_ACC_W  = 16;
  localparam int PE_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_e;

endpackage

// File: rtl/pe_acc_adder.sv
// Combinational accumulator adder: acc + zero-extended operand, with carry out.
// Build option PE_ACC_SATURATE_EN clamps the sum to all-ones on carry.
module pe_acc_adder
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  // One extra bit captures the carry; the size cast also covers ACC_W == DATA_W.
  assign raw   = {1'b0, acc} + (ACC_W+1)'(operand);
  assign carry = raw[ACC_W];

`ifdef PE_ACC_SATURATE_EN
  assign sum = carry ? '1 : raw[ACC_W-1:0];
`else
  assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/pe_operand_accumulator.sv
// Sums a programmed number of unsigned operands into an ACC_W result with
// valid/ready on both sides. Optional clamp-on-overflow: PE_ACC_SATURATE_EN.
module pe_operand_accumulator
  import pe_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W,
  parameter int ACC_W  = PE_ACC_W,
  parameter int CNT_W  = PE_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              ovf
);

  pe_state_e        state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic             start_ok;
  logic             in_fire;

  assign start_ok = (state == IDLE) && start;
  assign in_fire  = (state == ACCUM) && in_valid;

  pe_acc_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc     (acc),
    .operand (in_data),
    .sum     (sum),
    .carry   (carry)
  );

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (in_valid && (cnt == CNT_W'(1))) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    ;
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // acc holds still in DONE, so out_data is stable until the result handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (start_ok) begin
      acc   <= '0;
      cnt   <= len;
      ovf_q <= 1'b0;
    end else if (in_fire) begin
      acc   <= sum;
      cnt   <= cnt - 1'b1;
      ovf_q <= ovf_q | carry;
    end
  end

  assign out_data = acc;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_pe_operand_accumulator.sv
// Self-checking bench: a 16-bit and an 8-bit accumulator share one stimulus
// stream and are compared against an arithmetic reference model.
module tb_pe_operand_accumulator;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready16, out_valid16, busy16, ovf16;
  logic [15:0] out_data16;
  logic        in_ready8, out_valid8, busy8, ovf8;
  logic [7:0]  out_data8;

  int total = 0;
  int bad   = 0;
  logic [7:0] ops[$];

  pe_operand_accumulator dut16 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready16),
    .out_data  (out_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready),
    .busy      (busy16),
    .ovf       (ovf16)
  );

  pe_operand_accumulator #(.ACC_W(8)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .busy      (busy8),
    .ovf       (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the job result is the plain integer sum of the operands, reduced
  // to the accumulator width; overflow means the true sum does not fit.
  function automatic void model(input int w, output logic [31:0] res, output logic ov);
    longint sum_all = 0;
    longint lim = longint'(1) << w;
    foreach (ops[i]) sum_all += longint'(ops[i]);
    ov = (sum_all >= lim);
`ifdef PE_ACC_SATURATE_EN
    res = ov ? 32'(lim - 1) : 32'(sum_all);
`else
    res = 32'(sum_all % lim);
`endif
  endfunction

  // Runs one job from IDLE using the operands in ops. gap idle cycles precede
  // every operand after the first; bp cycles of result backpressure; poke
  // drives start during ACCUM and on the result handshake.
  task automatic do_job(input int gap, input int bp, input bit poke);
    logic [31:0] exp16, exp8;
    logic        ov16, ov8;
    model(16, exp16, ov16);
    model(8, exp8, ov8);
    start = 1'b1;
    len   = 8'(ops.size());
    step();
    start = 1'b0;
    check("ovf16_cleared_on_start", ovf16, 0);
    check("ovf8_cleared_on_start", ovf8, 0);
    if (ops.size() > 0) begin
      check("in_ready_in_accum", in_ready16, 1);
      check("busy_in_accum", busy16, 1);
      check("no_out_valid_in_accum", out_valid16, 0);
      foreach (ops[i]) begin
        if (i > 0) begin
          repeat (gap) begin
            in_valid = 1'b0;
            step();
            check("in_ready_held_in_stall", in_ready16, 1);
          end
        end
        in_valid = 1'b1;
        in_data  = ops[i];
        if (poke && i == 0) begin
          start = 1'b1;
          len   = 8'd1;
        end
        step();
        start = 1'b0;
      end
      in_valid = 1'b0;
      in_data  = $urandom;
    end
    check("out_valid_after_last", out_valid16, 1);
    check("out_valid8_after_last", out_valid8, 1);
    check("in_ready_low_in_done", in_ready16, 0);
    check("out_data16", out_data16, exp16);
    check("out_data8", out_data8, exp8);
    check("ovf16", ovf16, ov16);
    check("ovf8", ovf8, ov8);
    repeat (bp) begin
      step();
      check("out_valid_held", out_valid16, 1);
      check("out_data_held", out_data16, exp16);
    end
    out_ready = 1'b1;
    if (poke) begin
      start = 1'b1;
      len   = 8'd1;
    end
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check("out_valid_drop", out_valid16, 0);
    check("idle_after_handshake", busy16, 0);
    check("in_ready_idle", in_ready16, 0);
    if (poke) begin
      step();
      check("start_in_done_ignored", busy16, 0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid16, 0);
    check("rst_in_ready", in_ready16, 0);
    check("rst_busy", busy16, 0);
    check("rst_ovf", ovf16, 0);
    check("rst_out_data", out_data16, 0);
    reset_n = 1'b1;
    step();

    // Basic sum, back-to-back.
    ops = '{8'h10, 8'h20, 8'h30};
    do_job(0, 0, 0);

    // Input stalls 1-0-0-1 with four cycles of backpressure.
    ops = '{8'h05, 8'h07};
    do_job(2, 4, 0);

    // Zero-length job.
    ops = '{};
    do_job(0, 0, 0);

    // Overflow in the 8-bit accumulator; the next start clears ovf.
    ops = '{8'hFF, 8'h02};
    do_job(0, 1, 0);

    // start pokes during ACCUM and on the DONE handshake.
    ops = '{8'h11, 8'h22};
    do_job(0, 0, 1);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      int n;
      n = $urandom_range(1, 6);
      ops = '{};
      for (int k = 0; k < n; k++) ops.push_back(8'($urandom));
      do_job($urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-job after two 0xFF operands.
    start = 1'b1;
    len   = 8'd4;
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    step();
    in_valid = 1'b0;
    check("pre_reset_ovf8", ovf8, 1);
    check("pre_reset_busy", busy16, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid16, 0);
    check("midrst_in_ready", in_ready16, 0);
    check("midrst_busy", busy16, 0);
    check("midrst_ovf8", ovf8, 0);
    check("midrst_out_data16", out_data16, 0);
    check("midrst_out_data8", out_data8, 0);
    #1;
    reset_n = 1'b1;
    step();
    ops = '{8'h09};
    do_job(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
